// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph table (bit0=a .. bit6=g),
// blank pattern and the capture FSM state type.
package seg7_pkg;

  localparam int SEG7_NUM_GLYPHS = 16;

  // Same table drives the display encode path, so loopback compares like with like.
  localparam logic [6:0] SEG7_CODE [SEG7_NUM_GLYPHS] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_DONE = 1'b1
  } seg7_state_t;

endpackage : seg7_pkg

// File: rtl/seg7_pattern_lut.sv
// Reverse glyph lookup: active-low segment pattern -> {hit, nibble}.
// Misses (including the blank pattern) report hit=0, nibble=0.
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_hit,
  output logic [3:0] o_nibble
);

  // Table entries are distinct, so at most one comparison can match.
  always_comb begin
    o_hit    = 1'b0;
    o_nibble = 4'h0;
    for (int n = 0; n < SEG7_NUM_GLYPHS; n++) begin
      if (i_pattern == SEG7_CODE[n]) begin
        o_hit    = 1'b1;
        o_nibble = 4'(n);
      end
    end
  end

endmodule : seg7_pattern_lut

// File: rtl/seg7_capture.sv
// Captures a multiplexed active-low 7-segment bus back into per-digit nibbles,
// committing a frame only after it has been stable. Optional: SEG7_BLANK_DETECT_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            seg_i,
  input  logic [N_DIGITS-1:0]   dig_sel_i,
  output logic [4*N_DIGITS-1:0] hex_o,
  output logic [N_DIGITS-1:0]   valid_o,
  output logic                  update_o,
  output logic [2:0]            upd_idx_o,
  output logic                  err_o
);

  localparam int FW = N_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_EVAL = CW'(STABLE_CYCLES - 1);

  logic [FW-1:0]             w_frame;
  logic [FW-1:0]             r_sample;
  logic [CW-1:0]             r_cnt;
  seg7_state_t               r_state;
  logic [N_DIGITS-1:0][3:0]  r_hex;
  logic [N_DIGITS-1:0]       r_valid;
  logic                      r_update;
  logic [2:0]                r_updIdx;
  logic                      r_err;

  logic [N_DIGITS-1:0]       w_sel;
  logic [6:0]                w_seg;
  logic                      w_selZero;
  logic                      w_multiHot;
  logic [IW-1:0]             w_idx;
  logic                      w_hit;
  logic [3:0]                w_nibble;
  logic                      w_isBlank;

  assign w_frame    = {dig_sel_i, seg_i};
  assign w_sel      = r_sample[FW-1:7];
  assign w_seg      = r_sample[6:0];
  assign w_selZero  = (w_sel == '0);
  assign w_multiHot = |(w_sel & (w_sel - N_DIGITS'(1)));
  assign w_isBlank  = (w_seg == SEG7_BLANK);

  always_comb begin
    w_idx = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (w_sel[d]) w_idx = IW'(d);
    end
  end

  seg7_pattern_lut u_lut (
    .i_pattern (w_seg),
    .o_hit     (w_hit),
    .o_nibble  (w_nibble)
  );

  // Any input change restarts the stability window; a settled frame is evaluated exactly once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sample <= '0;
      r_cnt    <= '0;
      r_state  <= S_WAIT;
      r_hex    <= '0;
      r_valid  <= '0;
      r_update <= 1'b0;
      r_updIdx <= 3'd0;
      r_err    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_err    <= 1'b0;
      if (w_frame != r_sample) begin
        r_sample <= w_frame;
        r_cnt    <= '0;
        r_state  <= S_WAIT;
      end else if (r_state == S_WAIT) begin
        if (r_cnt < CNT_MAX) r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CNT_EVAL) begin
          r_state <= S_DONE;
          // All-zero select is the blanking gap between digits: silently ignored.
          if (!w_selZero) begin
            if (w_multiHot) begin
              r_err <= 1'b1;
`ifdef SEG7_BLANK_DETECT_EN
            end else if (w_isBlank) begin
              r_hex[w_idx]   <= 4'h0;
              r_valid[w_idx] <= 1'b0;
              r_update       <= 1'b1;
              r_updIdx       <= 3'(w_idx);
`endif
            end else if (w_hit) begin
              r_hex[w_idx]   <= w_nibble;
              r_valid[w_idx] <= 1'b1;
              r_update       <= 1'b1;
              r_updIdx       <= 3'(w_idx);
            end else begin
              r_err          <= 1'b1;
              r_valid[w_idx] <= 1'b0;
            end
          end
        end
      end
    end
  end

`ifndef SEG7_BLANK_DETECT_EN
  // Blank falls through to the unknown-pattern branch when detection is off.
  logic w_unusedBlank;
  assign w_unusedBlank = w_isBlank;
`endif

  assign hex_o     = r_hex;
  assign valid_o   = r_valid;
  assign update_o  = r_update;
  assign upd_idx_o = r_updIdx;
  assign err_o     = r_err;

endmodule : seg7_capture

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture (N_DIGITS=4, STABLE_CYCLES=4).
// Define SEG7_BLANK_DETECT_EN for both bench and RTL to test the blank option.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  digSel = 4'd0;
  logic [15:0] hexOut;
  logic [3:0]  validOut;
  logic        updateOut;
  logic [2:0]  updIdx;
  logic        errOut;

  int assertCount = 0;
  int failCount   = 0;
  int updCount    = 0;
  int errCount    = 0;
  int updBase;
  int errBase;

  always #5 clk = ~clk;

  seg7_capture #(
    .N_DIGITS      (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .seg_i     (seg),
    .dig_sel_i (digSel),
    .hex_o     (hexOut),
    .valid_o   (validOut),
    .update_o  (updateOut),
    .upd_idx_o (updIdx),
    .err_o     (errOut)
  );

  // Pulse counters sampled mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (updateOut) updCount++;
    if (errOut)    errCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] pattern, input int cycles);
    digSel = sel;
    seg    = pattern;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with an idle bus
    rst = 1'b1;
    tick(2);
    checkOutput("reset_hex", 32'(hexOut), 32'h0);
    checkOutput("reset_valid", 32'(validOut), 32'h0);
    checkOutput("reset_update", 32'(updateOut), 32'h0);
    checkOutput("reset_err", 32'(errOut), 32'h0);
    checkOutput("reset_idx", 32'(updIdx), 32'h0);
    rst = 1'b0;
    tick(6);

    // 1: digit 0 = '3', commit after the 5th equal sample, then no refresh pulse
    updBase = updCount;
    applyStimulus(4'b0001, 7'b0110000, 4);
    checkOutput("t1_no_early_update", 32'(updateOut), 32'h0);
    tick(1);
    checkOutput("t1_update", 32'(updateOut), 32'h1);
    checkOutput("t1_idx", 32'(updIdx), 32'h0);
    checkOutput("t1_hex", 32'(hexOut[3:0]), 32'h3);
    checkOutput("t1_valid", 32'(validOut), 32'h1);
    tick(20);
    checkOutput("t1_single_pulse", 32'(updCount - updBase), 32'd1);

    // 2: glitch restarts the count
    updBase = updCount;
    applyStimulus(4'b0001, 7'b0010010, 4);
    applyStimulus(4'b0001, 7'b0010011, 1);
    applyStimulus(4'b0001, 7'b0010010, 4);
    checkOutput("t2_no_update_after_glitch", 32'(updCount - updBase), 32'd0);
    checkOutput("t2_hex_held", 32'(hexOut[3:0]), 32'h3);
    tick(1);
    checkOutput("t2_update", 32'(updateOut), 32'h1);
    checkOutput("t2_hex", 32'(hexOut[3:0]), 32'h5);
    tick(5);
    checkOutput("t2_single_pulse", 32'(updCount - updBase), 32'd1);

    // 3: scan 0,A,C,F across digits 0..3 with blanking gaps
    updBase = updCount;
    errBase = errCount;
    applyStimulus(4'b0001, 7'b1000000, 8);
    applyStimulus(4'b0000, 7'b1111111, 2);
    applyStimulus(4'b0010, 7'b0001000, 8);
    applyStimulus(4'b0000, 7'b1111111, 2);
    applyStimulus(4'b0100, 7'b1000110, 8);
    applyStimulus(4'b0000, 7'b1111111, 2);
    applyStimulus(4'b1000, 7'b0001110, 8);
    applyStimulus(4'b0000, 7'b1111111, 2);
    checkOutput("t3_hex", 32'(hexOut), 32'hFCA0);
    checkOutput("t3_valid", 32'(validOut), 32'hF);
    checkOutput("t3_updates", 32'(updCount - updBase), 32'd4);
    checkOutput("t3_no_err", 32'(errCount - errBase), 32'd0);
    checkOutput("t3_last_idx", 32'(updIdx), 32'd3);

    // 4: multi-hot select, then unknown pattern on digit 2
    updBase = updCount;
    errBase = errCount;
    applyStimulus(4'b0110, 7'b1111001, 5);
    checkOutput("t4_multihot_err", 32'(errOut), 32'h1);
    checkOutput("t4_multihot_no_update", 32'(updateOut), 32'h0);
    checkOutput("t4_multihot_valid", 32'(validOut), 32'hF);
    tick(1);
    checkOutput("t4_err_one_cycle", 32'(errOut), 32'h0);
    applyStimulus(4'b0100, 7'b1010101, 5);
    checkOutput("t4_unknown_err", 32'(errOut), 32'h1);
    checkOutput("t4_valid", 32'(validOut), 32'hB);
    checkOutput("t4_hex", 32'(hexOut), 32'hFCA0);
    tick(3);
    checkOutput("t4_err_count", 32'(errCount - errBase), 32'd2);
    checkOutput("t4_no_updates", 32'(updCount - updBase), 32'd0);

    // 5: blank pattern on digit 1 (which holds 'A')
    applyStimulus(4'b0010, 7'b1111111, 5);
    checkOutput("t5_valid", 32'(validOut), 32'h9);
`ifdef SEG7_BLANK_DETECT_EN
    checkOutput("t5_update", 32'(updateOut), 32'h1);
    checkOutput("t5_err", 32'(errOut), 32'h0);
    checkOutput("t5_idx", 32'(updIdx), 32'd1);
    checkOutput("t5_hex", 32'(hexOut), 32'hFC00);
`else
    checkOutput("t5_update", 32'(updateOut), 32'h0);
    checkOutput("t5_err", 32'(errOut), 32'h1);
    checkOutput("t5_hex", 32'(hexOut), 32'hFCA0);
`endif

    // 6: reset mid-count; the frame must re-stabilise from scratch
    applyStimulus(4'b1000, 7'b0010000, 2);
    rst = 1'b1;
    tick(1);
    checkOutput("t6_hex_cleared", 32'(hexOut), 32'h0);
    checkOutput("t6_valid_cleared", 32'(validOut), 32'h0);
    checkOutput("t6_update_cleared", 32'(updateOut), 32'h0);
    checkOutput("t6_idx_cleared", 32'(updIdx), 32'h0);
    rst = 1'b0;
    tick(4);
    checkOutput("t6_no_early_update", 32'(updateOut), 32'h0);
    tick(1);
    checkOutput("t6_update", 32'(updateOut), 32'h1);
    checkOutput("t6_idx", 32'(updIdx), 32'd3);
    checkOutput("t6_hex", 32'(hexOut), 32'h9000);
    checkOutput("t6_valid", 32'(validOut), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_seg7_capture
